// File: rtl/nios_sysid_checker.sv
// Boot-time system-ID checker: reads the sysid ID and timestamp words over Avalon-MM
// and publishes a pass/fail verdict. Optional periodic re-check: SYSID_CHECK_PERIODIC_EN.
module nios_sysid_checker #(
    parameter logic [31:0] EXPECTED_ID = 32'd0,
    parameter logic [31:0] EXPECTED_TS = 32'd1624360340,
    parameter int unsigned TIMEOUT     = 255
`ifdef SYSID_CHECK_PERIODIC_EN
   ,parameter int unsigned RECHECK_CYCLES = 50000000
`endif
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic [31:0] id_value,
    output logic [31:0] ts_value,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        timeout
);

    typedef enum logic [1:0] {S_IDLE, S_RD_ID, S_RD_TS, S_DONE} state_t;

    localparam logic [16:0] TIMEOUT_W = 17'(TIMEOUT);

    state_t      state_q, state_d;
    logic [15:0] wait_q, wait_d;
    logic [31:0] id_q, id_d, ts_q, ts_d;
    logic        read_q, read_d, addr_q, addr_d, busy_q, busy_d;
    logic        done_q, done_d, pass_q, pass_d, timeout_q, timeout_d;
    logic        accept, stalled, stall_limit, launch, conclude;

    assign accept      = read_q && !avm_waitrequest;
    assign stalled     = read_q && avm_waitrequest;
    assign stall_limit = stalled && (({1'b0, wait_q} + 17'd1) >= TIMEOUT_W);

`ifdef SYSID_CHECK_PERIODIC_EN
    localparam logic [32:0] RECHECK_W = 33'(RECHECK_CYCLES);
    logic [31:0] idle_q, idle_d;
    logic        recheck;

    assign recheck = (({1'b0, idle_q} + 33'd1) >= RECHECK_W);
    assign idle_d  = (state_q == S_DONE && state_d == S_DONE) ? idle_q + 32'd1 : '0;

    always_ff @(posedge clock) begin
        if (reset) idle_q <= '0;
        else       idle_q <= idle_d;
    end
`endif

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        id_d      = id_q;
        ts_d      = ts_q;
        read_d    = read_q;
        addr_d    = addr_q;
        busy_d    = busy_q;
        done_d    = done_q;
        pass_d    = pass_q;
        timeout_d = timeout_q;
        launch    = 1'b0;
        conclude  = 1'b0;
        unique case (state_q)
            // IDLE is only the reset state; the boot check launches unconditionally.
            S_IDLE: launch = 1'b1;
            S_RD_ID: begin
                if (accept) begin
                    id_d    = avm_readdata;
                    state_d = S_RD_TS;
                    addr_d  = 1'b1;
                    wait_d  = '0;
                end else if (stall_limit) begin
                    id_d      = '0;
                    timeout_d = 1'b1;
                    conclude  = 1'b1;
                end else if (stalled) begin
                    wait_d = wait_q + 16'd1;
                end
            end
            S_RD_TS: begin
                if (accept) begin
                    ts_d     = avm_readdata;
                    pass_d   = (id_q == EXPECTED_ID) && (avm_readdata == EXPECTED_TS);
                    conclude = 1'b1;
                end else if (stall_limit) begin
                    ts_d      = '0;
                    timeout_d = 1'b1;
                    conclude  = 1'b1;
                end else if (stalled) begin
                    wait_d = wait_q + 16'd1;
                end
            end
            S_DONE: begin
`ifdef SYSID_CHECK_PERIODIC_EN
                launch = start || recheck;
`else
                launch = start;
`endif
            end
            default: state_d = S_IDLE;
        endcase
        if (conclude) begin
            state_d = S_DONE;
            read_d  = 1'b0;
            addr_d  = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            wait_d  = '0;
        end
        if (launch) begin
            state_d   = S_RD_ID;
            read_d    = 1'b1;
            addr_d    = 1'b0;
            busy_d    = 1'b1;
            done_d    = 1'b0;
            pass_d    = 1'b0;
            timeout_d = 1'b0;
            wait_d    = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            wait_q    <= '0;
            id_q      <= '0;
            ts_q      <= '0;
            read_q    <= 1'b0;
            addr_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            id_q      <= id_d;
            ts_q      <= ts_d;
            read_q    <= read_d;
            addr_q    <= addr_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            timeout_q <= timeout_d;
        end
    end

    assign avm_address = addr_q;
    assign avm_read    = read_q;
    assign id_value    = id_q;
    assign ts_value    = ts_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_nios_sysid_checker.sv
// Self-checking bench for nios_sysid_checker: a per-cycle timeline model of each check
// plus literal expectations; exercises SYSID_CHECK_PERIODIC_EN when that macro is defined.
module tb_nios_sysid_checker;

    localparam int          NCYC   = 1024;
    localparam int          TO     = 4;
    localparam logic [31:0] EXP_ID = 32'd0;
    localparam logic [31:0] EXP_TS = 32'd1624360340;
`ifdef SYSID_CHECK_PERIODIC_EN
    localparam int          RECHK  = 10;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        avm_address, avm_read, avm_waitrequest;
    logic [31:0] avm_readdata, id_value, ts_value;
    logic        busy, done, pass, timeout;

    logic [31:0] mem0 = 32'd0;
    logic [31:0] mem1 = 32'd1624360340;
    int          stall_n = 0;
    bit          stuck = 1'b0;
    int          stall_cnt = 0;
    int          cyc = 0;
    int          vectors = 0;
    int          errors = 0;

    bit          e_read [NCYC];
    bit          e_addr [NCYC];
    bit          e_busy [NCYC];
    bit          e_done [NCYC];
    bit          e_pass [NCYC];
    bit          e_to   [NCYC];
    logic [31:0] e_id   [NCYC];
    logic [31:0] e_ts   [NCYC];

    nios_sysid_checker #(
        .EXPECTED_ID(EXP_ID),
        .EXPECTED_TS(EXP_TS),
        .TIMEOUT(TO)
`ifdef SYSID_CHECK_PERIODIC_EN
       ,.RECHECK_CYCLES(RECHK)
`endif
    ) dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .avm_address(avm_address),
        .avm_read(avm_read),
        .avm_readdata(avm_readdata),
        .avm_waitrequest(avm_waitrequest),
        .id_value(id_value),
        .ts_value(ts_value),
        .busy(busy),
        .done(done),
        .pass(pass),
        .timeout(timeout)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Slave: stalls each request for stall_n cycles, or forever when stuck.
    assign avm_readdata    = avm_address ? mem1 : mem0;
    assign avm_waitrequest = stuck || (stall_cnt < stall_n);
    always @(posedge clock) begin
        if (reset || !avm_read || !avm_waitrequest) stall_cnt <= 0;
        else                                        stall_cnt <= stall_cnt + 1;
    end

    task automatic put(input int k, input bit r, input bit a, input bit b, input bit d,
                       input bit p, input bit t, input logic [31:0] idv, input logic [31:0] tsv);
        if (k >= 0 && k < NCYC) begin
            e_read[k] = r; e_addr[k] = a; e_busy[k] = b; e_done[k] = d;
            e_pass[k] = p; e_to[k] = t; e_id[k] = idv; e_ts[k] = tsv;
        end
    endtask

    // A check launched so that cycle c0 is its first read cycle: each read lasts stall_n+1
    // cycles, or TO cycles if the slave would stall TO times, which ends the check early.
    task automatic plan_check(input int c0);
        int          c, len;
        bit          to, pv;
        logic [31:0] idv, tsv;
        c   = c0;
        idv = e_id[c0-1];
        tsv = e_ts[c0-1];
        while (c < NCYC) begin
            to  = stuck || (stall_n >= TO);
            len = to ? TO : stall_n + 1;
            for (int j = 0; j < len; j++)
                put(c + j, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, idv, tsv);
            c += len;
            idv = to ? 32'd0 : mem0;
            if (!to) begin
                for (int j = 0; j < len; j++)
                    put(c + j, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, idv, tsv);
                c += len;
                tsv = mem1;
            end
            pv = !to && (idv == EXP_ID) && (tsv == EXP_TS);
`ifdef SYSID_CHECK_PERIODIC_EN
            for (int j = 0; j < RECHK; j++)
                put(c + j, 1'b0, 1'b0, 1'b0, 1'b1, pv, to, idv, tsv);
            c += RECHK;
`else
            for (int j = c; j < NCYC; j++)
                put(j, 1'b0, 1'b0, 1'b0, 1'b1, pv, to, idv, tsv);
            c = NCYC;
`endif
        end
    endtask

    task automatic tick();
        @(negedge clock);
        if (cyc >= 1 && cyc < NCYC) begin
            vectors++;
            if ({avm_read, avm_address, busy, done, pass, timeout} !==
                {e_read[cyc], e_addr[cyc], e_busy[cyc], e_done[cyc], e_pass[cyc], e_to[cyc]} ||
                id_value !== e_id[cyc] || ts_value !== e_ts[cyc]) begin
                errors++;
                $display("FAIL cycle %0d outputs: got rd=%b ad=%b busy=%b done=%b pass=%b to=%b id=%h ts=%h, want rd=%b ad=%b busy=%b done=%b pass=%b to=%b id=%h ts=%h",
                         cyc, avm_read, avm_address, busy, done, pass, timeout, id_value, ts_value,
                         e_read[cyc], e_addr[cyc], e_busy[cyc], e_done[cyc], e_pass[cyc], e_to[cyc],
                         e_id[cyc], e_ts[cyc]);
            end
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %b want %b", name, cyc, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d want %0d", name, cyc, act, exp);
        end
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) tick();
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        start = 1'b0;
        for (int j = cyc + 1; j < NCYC; j++)
            put(j, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (n) tick();
        reset = 1'b0;
        plan_check(cyc + 1);
    endtask

    // start is only honoured when the check is finished in the cycle it is sampled after.
    task automatic pulse_start(output int k);
        k = cyc;
        start = 1'b1;
        if (e_done[k]) plan_check(k + 1);
        tick();
        start = 1'b0;
    endtask

    task automatic start_check(input logic [31:0] d0, input logic [31:0] d1, input int sn,
                               input bit st, output int k);
        int n;
        n = 0;
        while (!e_done[cyc] && n < 200) begin
            tick();
            n++;
        end
        if (!e_done[cyc]) begin
            vectors++;
            errors++;
            $display("FAIL start_wait at cycle %0d: got no verdict window want one", cyc);
        end
        mem0 = d0; mem1 = d1; stall_n = sn; stuck = st;
        pulse_start(k);
    endtask

    initial begin
        int rel, k, d, kk;
        do_reset(3);
        rel = cyc;
        chk1("reset_read", avm_read, 1'b0);
        chk1("reset_busy", busy, 1'b0);
        chk32("reset_id", id_value, 32'd0);
        wait_until(rel + 2);
        chk1("boot_rdts_addr", avm_address, 1'b1);
        chk1("boot_rdts_done", done, 1'b0);
        wait_until(rel + 3);
        chk1("boot_done", done, 1'b1);
        chk1("boot_pass", pass, 1'b1);
        chk32("boot_ts", ts_value, 32'd1624360340);

        start_check(32'd1, EXP_TS, 0, 1'b0, k);
        wait_until(k + 3);
        chk1("badid_done", done, 1'b1);
        chk1("badid_pass", pass, 1'b0);
        chk1("badid_timeout", timeout, 1'b0);
        chk32("badid_id", id_value, 32'd1);

        start_check(32'd0, EXP_TS, 3, 1'b0, k);
        wait_until(k + 3);
        chk1("stall_read_held", avm_read, 1'b1);
        chk1("stall_addr_held", avm_address, 1'b0);
        wait_until(k + 8);
        chk1("stall_not_done", done, 1'b0);
        wait_until(k + 9);
        chk1("stall_done", done, 1'b1);
        chk1("stall_pass", pass, 1'b1);

        start_check(32'd0, EXP_TS, 0, 1'b1, k);
        wait_until(k + 4);
        chk1("stuck_read_last", avm_read, 1'b1);
        wait_until(k + 5);
        chk1("stuck_read_drop", avm_read, 1'b0);
        chk1("stuck_timeout", timeout, 1'b1);
        chk1("stuck_pass", pass, 1'b0);

        start_check(32'd0, EXP_TS, 0, 1'b0, k);
        wait_until(k + 3);
        chk1("recover_timeout", timeout, 1'b0);
        chk1("recover_pass", pass, 1'b1);

        start_check(32'd0, EXP_TS, 2, 1'b0, k);
        wait_until(k + 4);
        chk1("ign_in_rdts", avm_address, 1'b1);
        pulse_start(kk);
        wait_until(k + 7);
        chk1("ign_done", done, 1'b1);
        wait_until(k + 12);
        chk1("ign_single_verdict", busy, 1'b0);

        start_check(32'd0, EXP_TS, 2, 1'b0, k);
        wait_until(k + 5);
        do_reset(1);
        chk1("midreset_read", avm_read, 1'b0);
        chk32("midreset_id", id_value, 32'd0);
        wait_until(k + 13);
        chk1("midreset_done", done, 1'b1);
        chk1("midreset_pass", pass, 1'b1);

        start_check(32'd0, EXP_TS, 0, 1'b0, k);
        d = k + 3;
        wait_until(d + 10);
`ifdef SYSID_CHECK_PERIODIC_EN
        chk1("recheck_busy", busy, 1'b1);
        chk1("recheck_addr", avm_address, 1'b0);
        wait_until(d + 11);
        chk1("recheck_busy2", busy, 1'b1);
`else
        chk1("terminal_busy", busy, 1'b0);
        chk1("terminal_done", done, 1'b1);
`endif
        wait_until(d + 12);
        chk1("final_done", done, 1'b1);
        chk1("final_pass", pass, 1'b1);

        repeat (20) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/nios_sysid_checker.md
# nios_sysid_checker

Avalon-MM master that consumes the system-ID slave's `readdata`: after reset (or on `start`) it reads the ID word (address 0) and the build-timestamp word (address 1), compares both against compile-time expected values, and publishes a pass/fail verdict. Sits directly downstream of the sysid control slave, through the Qsys interconnect. Software and the boot LED logic use the verdict to refuse a mismatched FPGA image before the CPU runs application code.

## Interface
- `EXPECTED_ID`, 0, expected 32-bit system ID word (address 0)
- `EXPECTED_TS`, 1624360340, expected 32-bit timestamp word (address 1)
- `TIMEOUT`, 255, maximum cycles a read may stall on `avm_waitrequest` before it is aborted (1..65535)
- `RECHECK_CYCLES`, 50000000, idle cycles between automatic re-checks (used only with `SYSID_CHECK_PERIODIC_EN`)

- `clock`  in  1  single clock; all logic is rising-edge
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  one-cycle pulse requesting a new check; ignored unless in IDLE or DONE
- `avm_address`  out  1  0 = ID word, 1 = timestamp word
- `avm_read`  out  1  read request, held until accepted
- `avm_readdata`  in  32  read data, valid in the cycle `avm_read`=1 and `avm_waitrequest`=0
- `avm_waitrequest`  in  1  interconnect stall
- `id_value`  out  32  last captured ID word
- `ts_value`  out  32  last captured timestamp word
- `busy`  out  1  check in progress
- `done`  out  1  verdict valid (sticky until next check starts)
- `pass`  out  1  both words matched; qualified by `done`
- `timeout`  out  1  a read exceeded `TIMEOUT`; qualified by `done`

## Operation
- States: IDLE, RD_ID, RD_TS, DONE.
- Reset: state→RD_ID on the first cycle after reset deasserts (automatic boot check); all outputs 0 during reset (`avm_read`, `avm_address`, `id_value`, `ts_value`, `busy`, `done`, `pass`, `timeout`).
- IDLE: entered only via reset release path; `start`=1 → RD_ID.
- RD_ID: `avm_address`=0, `avm_read`=1, `busy`=1, `done`=0. On accept, `id_value`←`avm_readdata`, → RD_TS.
- RD_TS: `avm_address`=1, `avm_read`=1. On accept, `ts_value`←`avm_readdata`, → DONE.
- DONE: `avm_read`=0, `busy`=0, `done`=1, `pass`=(`id_value`==`EXPECTED_ID`)&&(`ts_value`==`EXPECTED_TS`)&&!`timeout`. `start`=1 → RD_ID, clearing `done`, `pass` and `timeout` in that same transition.
- Wait counter: 16-bit, cleared on each state entry, increments each cycle `avm_read`=1 and `avm_waitrequest`=1. Reaching `TIMEOUT` → `avm_read` drops, `timeout`←1, the word stays 0, → DONE with `pass`=0.
- `start` while in RD_ID/RD_TS is ignored, with no queuing.
- Comparison is an exact 32-bit equality; there are no masks.

## Timing
- Accept is combinational on `avm_read`&&!`avm_waitrequest`. `avm_address` and `avm_read` are registered and stable while stalled.
- Zero-wait interconnect: reset release at cycle 0, RD_ID at cycle 1, RD_TS at cycle 2, DONE (`done`=1) at cycle 3. Total 3 cycles from reset release; 3 cycles from `start`.
- `pass` and `done` are registered and assert in the same cycle.
- `reset` mid-read aborts on the next edge: `avm_read`=0 immediately, then the boot check restarts.

## Configuration
- `SYSID_CHECK_PERIODIC_EN` defined: in DONE, a 32-bit counter counts idle cycles. At `RECHECK_CYCLES` it re-enters RD_ID exactly as if `start` had pulsed. The counter resets on any DONE entry or on `start`. The previous `id_value`/`ts_value` are retained until overwritten.
- Not defined: DONE is terminal except for `start`. The counter and the `RECHECK_CYCLES` logic are absent.

## Test plan
- Reset release, zero-wait slave returning 0 at addr 0 and 1624360340 at addr 1 -> `done`=1, `pass`=1 at cycle 3; `id_value`=0, `ts_value`=1624360340.
- Slave returns 0x00000001 at addr 0 -> `done`=1, `pass`=0, `timeout`=0, `id_value`=1.
- `avm_waitrequest` held 3 cycles per read -> `avm_address`/`avm_read` stable while stalled, `done` at cycle 9, `pass`=1.
- `avm_waitrequest` stuck high with `TIMEOUT`=4 -> `avm_read` drops after 4 stall cycles, `done`=1, `timeout`=1, `pass`=0. A later `start` with a healthy slave -> `timeout` clears, `pass`=1.
- `start` pulsed during RD_TS -> ignored, a single verdict results. `reset` pulsed during RD_TS -> outputs 0, a fresh check completes with `pass`=1.
- With `SYSID_CHECK_PERIODIC_EN` and `RECHECK_CYCLES`=10 -> RD_ID re-entered 10 cycles after DONE. `busy` high for 2 cycles, then `done` reasserts with `pass`=1.
